// File: rtl/gnr_attractor_ctrl_pkg.sv
// Shared state encoding and default widths for the GRN attractor-search controller.
package gnr_ctrl_pkg;
  localparam int unsigned NODES_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    MEASURE = 3'd4,
    FIN     = 3'd5
  } state_e;
endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Controller <-> node-array link: load/step strobes out, both trajectory vectors back.
interface gnr_attractor_ctrl_if #(parameter int NODES = 4) ();
  logic             reset_nos;
  logic [NODES-1:0] init_state;
  logic             start_s0;
  logic             start_s1;
  logic [NODES-1:0] s0_vec;
  logic [NODES-1:0] s1_vec;

  modport master (output reset_nos, init_state, start_s0, start_s1,
                  input  s0_vec, s1_vec);
  modport slave  (input  reset_nos, init_state, start_s0, start_s1,
                  output s0_vec, s1_vec);
endinterface

// File: rtl/gnr_attractor_ctrl_step_cnt.sv
// Saturating up-counter with synchronous clear and an equality flag against a limit.
module gnr_step_cnt
  import gnr_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             eq
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, then increment unless already saturated
  always_comb begin
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign eq  = (cnt_q == limit);
endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Tortoise/hare attractor-search sequencer for one GRN node array.
// Define GNR_ATTRACTOR_PERIOD_EN to add the MEASURE state and the period counter.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int NODES = NODES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NODES-1:0]        init_vec,
  input  logic [CNT_W-1:0]        max_steps,
  gnr_attractor_ctrl_if.master    arr,
  output logic                    busy,
  output logic                    done,
  output logic                    met,
  output logic [CNT_W-1:0]        step_count,
  output logic [CNT_W-1:0]        period
);
  state_e           state_q, state_d, state_fsm;
  logic [NODES-1:0] init_q, init_d, init_state_q, init_state_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             reset_nos_q, reset_nos_d;
  logic             busy_q, busy_d, done_q, done_d, met_q, met_d;
  logic             accept, vec_eq, step_zero, step_eq, step_inc;
  logic             run_s0, run_s1;
  logic [CNT_W-1:0] step_cnt;

  assign accept    = (state_q == IDLE) && start;
  assign vec_eq    = (arr.s0_vec == arr.s1_vec);
  assign step_zero = (step_cnt == {CNT_W{1'b0}});

  gnr_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk(clk), .rst(rst), .clr(accept), .inc(step_inc),
    .limit(max_q), .cnt(step_cnt), .eq(step_eq)
  );

`ifdef GNR_ATTRACTOR_PERIOD_EN
  logic             per_inc, per_lim_clr, per_zero, per_eq;
  logic [CNT_W-1:0] per_cnt;

  assign per_zero = (per_cnt == {CNT_W{1'b0}});

  gnr_step_cnt #(.CNT_W(CNT_W)) u_period_cnt (
    .clk(clk), .rst(rst), .clr(accept | per_lim_clr), .inc(per_inc),
    .limit(max_q), .cnt(per_cnt), .eq(per_eq)
  );
  assign period = per_cnt;
`else
  assign period = {CNT_W{1'b0}};
`endif

  // next-state and strobe decode; step strobes stay combinational so the
  // meet/timeout cycle itself issues no step
  always_comb begin
    state_fsm = state_q;
    init_d    = init_q;
    max_d     = max_q;
    met_d     = met_q;
    step_inc  = 1'b0;
    run_s0    = 1'b0;
    run_s1    = 1'b0;
`ifdef GNR_ATTRACTOR_PERIOD_EN
    per_inc     = 1'b0;
    per_lim_clr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_fsm = LOAD;
          init_d    = init_vec;
          max_d     = max_steps;
          met_d     = 1'b0;
        end else begin
          state_fsm = IDLE;
        end
      end
      LOAD: state_fsm = SETTLE;
      SETTLE: begin
        if (max_q == {CNT_W{1'b0}}) begin
          met_d     = 1'b0;
          state_fsm = FIN;
        end else begin
          state_fsm = RUN;
        end
      end
      RUN: begin
        if (!step_zero && vec_eq) begin
`ifdef GNR_ATTRACTOR_PERIOD_EN
          state_fsm = MEASURE;
`else
          met_d     = 1'b1;
          state_fsm = FIN;
`endif
        end else if (step_eq) begin
          met_d     = 1'b0;
          state_fsm = FIN;
        end else begin
          run_s0   = 1'b1;
          run_s1   = 1'b1;
          step_inc = 1'b1;
        end
      end
`ifdef GNR_ATTRACTOR_PERIOD_EN
      MEASURE: begin
        if (!per_zero && vec_eq) begin
          met_d     = 1'b1;
          state_fsm = FIN;
        end else if (per_eq) begin
          met_d       = 1'b1;
          per_lim_clr = 1'b1;
          state_fsm   = FIN;
        end else begin
          run_s1  = 1'b1;
          per_inc = 1'b1;
        end
      end
`endif
      FIN:     state_fsm = IDLE;
      default: state_fsm = IDLE;
    endcase

    state_d      = (abort && (state_q != IDLE)) ? IDLE : state_fsm;
    reset_nos_d  = (state_d == LOAD);
    init_state_d = (state_d == LOAD) ? init_d : {NODES{1'b0}};
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

  // FSM state, latched run parameters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      init_q       <= {NODES{1'b0}};
      max_q        <= {CNT_W{1'b0}};
      met_q        <= 1'b0;
      reset_nos_q  <= 1'b0;
      init_state_q <= {NODES{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      max_q        <= max_d;
      met_q        <= met_d;
      reset_nos_q  <= reset_nos_d;
      init_state_q <= init_state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign arr.reset_nos  = reset_nos_q;
  assign arr.init_state = init_state_q;
  assign arr.start_s0   = run_s0;
  assign arr.start_s1   = run_s1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign met            = met_q;
  assign step_count     = step_cnt;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed + randomized bench for gnr_attractor_ctrl with a behavioural 4-node array
// and a trajectory-level reference model.
module tb_gnr_attractor_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  init_vec = 4'h0;
  logic [15:0] max_steps = 16'h0;
  logic        busy, done, met;
  logic [15:0] step_count, period;

  int total = 0;
  int bad   = 0;

  logic [3:0] lut [16];
  logic [3:0] s0_r, s1_r;
  logic       pass_r;

  gnr_attractor_ctrl_if #(.NODES(4)) arr ();

  gnr_attractor_ctrl #(.NODES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_vec(init_vec), .max_steps(max_steps), .arr(arr),
    .busy(busy), .done(done), .met(met),
    .step_count(step_count), .period(period)
  );

  always #5 clk = ~clk;

  // node array: s1 steps on every start_s1, s0 on every second start_s0
  always_ff @(posedge clk) begin
    if (arr.reset_nos) begin
      s0_r   <= arr.init_state;
      s1_r   <= arr.init_state;
      pass_r <= 1'b0;
    end else begin
      if (arr.start_s1) s1_r <= lut[s1_r];
      if (arr.start_s0) begin
        pass_r <= ~pass_r;
        if (pass_r) s0_r <= lut[s0_r];
      end
    end
  end
  assign arr.s0_vec = s0_r;
  assign arr.s1_vec = s1_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // trajectory-level model: after c steps s1 = f^c(init), s0 = f^(c/2)(init)
  function automatic void ref_run(input int init, input int mx,
                                  output int e_met, output int e_cnt,
                                  output int e_per, output int e_s1);
    int s0, s1, c, p, hit;
    e_met = 0; e_cnt = 0; e_per = 0; e_s1 = 0;
    if (mx == 0) return;
    s0 = init; s1 = init; c = 0; hit = 0;
    while (1) begin
      if (c != 0 && s0 == s1) begin hit = 1; break; end
      if (c == mx) break;
      s1 = int'(lut[s1]);
      if (c % 2 == 1) s0 = int'(lut[s0]);
      c++;
    end
    e_cnt = c; e_met = hit; e_s1 = c;
`ifdef GNR_ATTRACTOR_PERIOD_EN
    if (hit == 1) begin
      p = 0;
      while (1) begin
        if (p != 0 && s1 == s0) begin e_per = p; break; end
        if (p == mx) begin e_per = 0; break; end
        s1 = int'(lut[s1]);
        p++;
      end
      e_s1 = c + p;
    end
`endif
  endfunction

  // kind: 0 none, 1 abort, 2 rst, 3 start while busy -- applied at cycle evt_at
  task automatic do_run(input string tag, input logic [3:0] iv, input logic [15:0] mx,
                        input int evt_at, input int kind);
    int e_met, e_cnt, e_per, e_s1;
    int rn = 0, p0 = 0, p1 = 0, last = -10, done_cyc = -1;
    ref_run(int'(iv), int'(mx), e_met, e_cnt, e_per, e_s1);
    init_vec = iv; max_steps = mx; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (arr.reset_nos) rn++;
      if (arr.start_s0) p0++;
      if (arr.start_s1) begin p1++; last = cyc; end
      if (done) begin done_cyc = cyc; break; end
      if (cyc == evt_at && kind == 1) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_abort_starts"}, {30'd0, arr.start_s0, arr.start_s1}, 32'd0);
        repeat (2) begin
          chk({tag, "_abort_nodone"}, {31'd0, done}, 32'd0);
          tick();
        end
        return;
      end
      if (cyc == evt_at && kind == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_rst_outs"},
            {busy, done, met, arr.reset_nos, arr.start_s0, arr.start_s1, arr.init_state,
             (step_count != 16'd0), (period != 16'd0)}, 32'd0);
        return;
      end
      if (cyc == evt_at && kind == 3) begin
        start = 1'b1; init_vec = ~iv; max_steps = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, (done_cyc >= 0)}, 32'd1);
    chk({tag, "_met"}, {31'd0, met}, e_met);
    chk({tag, "_step_count"}, {16'd0, step_count}, e_cnt);
    chk({tag, "_period"}, {16'd0, period}, e_per);
    chk({tag, "_reset_nos_pulses"}, rn, 32'd1);
    chk({tag, "_s0_pulses"}, p0, e_cnt);
    chk({tag, "_s1_pulses"}, p1, e_s1);
    if (e_met == 0 && e_cnt > 0) chk({tag, "_done_timing"}, done_cyc, last + 2);
    tick();
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "_met_hold"}, {31'd0, met}, e_met);
  endtask

  initial begin
    int rst_at;
`ifdef GNR_ATTRACTOR_PERIOD_EN
    rst_at = 40;
`else
    rst_at = 20;
`endif
    repeat (3) tick();
    chk("reset_outs", {busy, done, met, arr.reset_nos, arr.start_s0, arr.start_s1,
                       arr.init_state, (step_count != 16'd0), (period != 16'd0)}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) lut[i] = 4'(i);
    do_run("c1_identity", 4'h5, 16'd10, -1, 0);

    for (int i = 0; i < 16; i++) lut[i] = 4'(i + 1);
    do_run("c2_incr", 4'h0, 16'd100, -1, 0);
    do_run("c3_timeout", 4'h0, 16'd3, -1, 0);
    do_run("c4_zero", 4'h0, 16'd0, -1, 0);
    do_run("c5_abort", 4'h0, 16'd100, 10, 1);
    do_run("c5_rerun", 4'h0, 16'd100, -1, 0);
    do_run("c6_rst", 4'h0, 16'd100, rst_at, 2);
    tick();
    do_run("c6_busy_start", 4'h0, 16'd100, 8, 3);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) lut[i] = 4'($urandom_range(0, 15));
      do_run($sformatf("rnd%0d", r), 4'($urandom_range(0, 15)),
             16'($urandom_range(0, 40)), -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
